// File: rtl/uart_tx_mmio_if.sv
// Write-side bus between the core store path and uart_tx_mmio: strobe/data in,
// FIFO status out.
interface uart_tx_mmio_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          busy;
   logic          overflow;
   logic [CW-1:0] count;

   modport master (output wr_en, wr_data, input full, busy, overflow, count);
   modport slave  (input wr_en, wr_data, output full, busy, overflow, count);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_mmio #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RESET,
   uart_tx_mmio_if.slave  bus,
   output logic           tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic          parity_q, parity_d;
`endif
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic full, push, pop, tick;

   // full is the pre-edge value, so a write while full is dropped even if a pop frees a slot
   assign full = (count_q == CW'(FIFO_DEPTH));
   assign push = bus.wr_en & ~full;
   assign tick = (baud_q == DIV_M1);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      pop      = 1'b0;
      if (state_q != IDLE) baud_d = tick ? 16'd0 : baud_q + 16'd1;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop      = 1'b1;
               shift_d  = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
               parity_d = ^mem_q[rptr_q];
`endif
               state_d  = START;
            end
         end
         START: if (tick) state_d = DATA;
         DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (bit_q == 3'd7) state_d = PARITY;
`else
               if (bit_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP: if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // tx is decoded from registered state so an async reset forces the line high at once
   always_comb begin
      tx = 1'b1;
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx = parity_q;
`endif
         default: tx = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (bus.wr_en && full) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wptr_q] <= bus.wr_data;
   end

   assign bus.full     = full;
   assign bus.busy     = (state_q != IDLE) | (count_q != '0);
   assign bus.overflow = overflow_q;
   assign bus.count    = count_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: queue-based reference model, per-cycle status checks
// and a UART frame decoder feeding a scoreboard.
module tb_uart_tx_mmio;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FLEN = NB * DIV;
   localparam logic [10:0] FMASK = 11'((1 << NB) - 1);

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic tx, tx1;

   uart_tx_mmio_if #(.FIFO_DEPTH(DEPTH)) bus ();
   uart_tx_mmio_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

   uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(clk), .RESET(rst_n), .bus(bus), .tx(tx));
   uart_tx_mmio #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH)) dut1 (
      .CLK(clk), .RESET(rst_n), .bus(bus1), .tx(tx1));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int e = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, e);
      end
   endtask

   // Line levels of one frame, index 0 = start bit, LSB-first data, [parity], stop
   function automatic logic [10:0] frame_bits(input logic [7:0] b);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   // Reference model: a byte queue plus the edge at which the current frame began.
   // A pop is possible once a full frame plus one idle cycle has elapsed.
   logic [7:0]  mfifo[$];
   logic [7:0]  exp_q[$];
   bit          movf = 1'b0;
   bit          full_pre;
   int          cur_p = -1000;
   logic [10:0] cur_f = '1;

   initial forever begin
      @(posedge clk);
      e++;
      if (!rst_n) begin
         mfifo.delete();
         exp_q.delete();
         movf  = 1'b0;
         cur_p = -1000;
      end else begin
         full_pre = (mfifo.size() == DEPTH);
         if (e >= cur_p + FLEN + 1 && mfifo.size() > 0) begin
            cur_f = frame_bits(mfifo.pop_front());
            cur_p = e;
         end
         if (bus.wr_en) begin
            if (!full_pre) begin
               mfifo.push_back(bus.wr_data);
               exp_q.push_back(bus.wr_data);
            end else movf = 1'b1;
         end
      end
   end

   logic exp_tx;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         check("rst_tx", tx, 1);
         check("rst_count", bus.count, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_overflow", bus.overflow, 0);
      end else begin
         exp_tx = (e >= cur_p && e < cur_p + FLEN) ? cur_f[(e - cur_p) / DIV] : 1'b1;
         check("tx", tx, exp_tx);
         check("count", bus.count, mfifo.size());
         check("full", bus.full, (mfifo.size() == DEPTH));
         check("busy", bus.busy, (mfifo.size() > 0 || e < cur_p + FLEN));
         check("overflow", bus.overflow, movf);
      end
   end

   // Frame decoder: samples mid-bit and compares each whole frame with the scoreboard
   int          starts[$];
   int          fc = 0;
   bit          inf = 1'b0;
   logic [10:0] rx = '1;
   initial forever begin
      @(negedge clk);
      if (!rst_n) inf = 1'b0;
      else begin
         if (!inf) begin
            if (tx === 1'b0) begin
               inf = 1'b1;
               fc  = 0;
               starts.push_back(e);
            end
         end else fc++;
         if (inf && (fc % DIV) == DIV / 2) begin
            rx[fc / DIV] = tx;
            if (fc / DIV == NB - 1) begin
               inf = 1'b0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL frame_unexpected: got frame %0h, expected none", rx & FMASK);
               end else
                  check("frame", 32'(rx & FMASK), 32'(frame_bits(exp_q.pop_front()) & FMASK));
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step(1);
      bus.wr_en   = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4000; i++) begin
         if (mfifo.size() == 0 && e >= cur_p + FLEN) break;
         step(1);
      end
      check("drain_busy", bus.busy, 0);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   logic [7:0]  rb;
   logic [10:0] f1;
   initial begin
      bus.wr_en = 1'b0;  bus.wr_data = '0;
      bus1.wr_en = 1'b0; bus1.wr_data = '0;
      #1 rst_n = 1'b0;
      step(3);
      check("reset_full", bus.full, 0);
      check("reset_count", bus.count, 0);
      rst_n = 1'b1;
      step(2);

      // single byte, exact timing checked cycle by cycle against the model
      wr(8'hA5);
      check("a5_count_after_write", bus.count, 1);
      step(60);

      // fill and overflow: 0x06 must be dropped
      for (int i = 1; i <= 6; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(i);
         step(1);
      end
      bus.wr_en = 1'b0;
      check("fill_full", bus.full, 1);
      check("fill_count", bus.count, 4);
      check("fill_overflow", bus.overflow, 1);
      drain();

      // back-to-back frames
      bus.wr_en = 1'b1; bus.wr_data = 8'h00; step(1);
      bus.wr_data = 8'hFF; step(1);
      bus.wr_en = 1'b0;
      drain();
      check("b2b_spacing", starts[$] - starts[$-1], FLEN + 1);

      // parity-sensitive bytes
      wr(8'h07);
      wr(8'h03);
      drain();

      // reset in the middle of data bit 3
      rb = 8'hA5;
      wr(rb);
      step(18);
      #2;
      check("pre_reset_tx", tx, rb[3]);
      rst_n = 1'b0;
      #1;
      check("midreset_tx", tx, 1);
      check("midreset_count", bus.count, 0);
      check("midreset_overflow", bus.overflow, 0);
      step(3);
      rst_n = 1'b1;
      step(60);

      // randomized traffic at three write densities
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 1500; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < (ph == 0 ? 3 : (ph == 1 ? 25 : 60)));
            bus.wr_data = 8'($urandom);
            step(1);
         end
         bus.wr_en = 1'b0;
         drain();
      end

      // CLK_DIV=1: every bit lasts one cycle
      f1 = frame_bits(8'h3C);
      bus1.wr_en = 1'b1; bus1.wr_data = 8'h3C;
      step(1);
      bus1.wr_en = 1'b0;
      check("div1_count", bus1.count, 1);
      step(1);
      for (int i = 0; i < NB; i++) begin
         check("div1_bit", tx1, f1[i]);
         step(1);
      end
      check("div1_idle_tx", tx1, 1);
      check("div1_idle_busy", bus1.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL timeout: got no completion, expected finish before 800000 ns");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter downstream of the core's output/LED write path.
- Core stores bytes via a one-cycle write strobe into a small FIFO; an FSM serialises them 8N1 (optionally 8E1) on `tx`.
- Gives the core a serial output channel alongside the 4-bit LED port; testbenches decode `tx` to print core output.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range 1..65535.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- wr_en  input  1  write strobe from core store path; one byte per asserted cycle.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- busy  output  1  FSM not IDLE, or FIFO non-empty.
- overflow  output  1  sticky; set when a write is dropped.
- count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (RESET=0, async): tx=1, busy=0, full=0, overflow=0, count=0, FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0. All outputs are registered or decoded from registered state.
- Push:
  - wr_en=1 with full=0: wr_data is written at the tail; count increments next edge.
  - wr_en=1 with full=1: byte dropped, FIFO unchanged, overflow=1 from next edge until reset.
  - `full` is the pre-edge value. A write while full is dropped even if a pop occurs in the same cycle.
- Pop: only in IDLE when count!=0. Head byte loads the shift register; FSM→START next edge.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: tx=1. If count!=0, pop, →START.
  - START: tx=0 for CLK_DIV cycles, →DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right. After bit 7, →PARITY if enabled, else →STOP.
  - STOP: tx=1 for CLK_DIV cycles, →IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 in every non-IDLE state.
  - State/bit advances on the cycle where counter==CLK_DIV-1, and counter wraps to 0.
  - CLK_DIV=1: every state lasts exactly one cycle.
- Timing:
  - Write at edge N → FIFO non-empty at N+1 → pop at N+1 → tx=0 from edge N+2.
  - Back-to-back frames: one IDLE cycle (tx=1) between STOP and next START, giving a frame period of 10*CLK_DIV+1 cycles (11*CLK_DIV+1 with parity).
- Pointer wrap: modulo FIFO_DEPTH, natural binary wrap. Occupancy is tracked by `count`, not pointer comparison.
- Reset mid-frame: tx returns high immediately (async). Frame aborted, FIFO contents discarded, overflow cleared.
- busy = (state!=IDLE) | (count!=0).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state between DATA and STOP; tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
- Undefined: PARITY state and its logic absent; DATA goes directly to STOP (8N1).

Test Plan:
- Single byte 0xA5 (CLK_DIV=4): wr_en pulse at edge 0 → tx=0 over edges 2–5; then bits 1,0,1,0,0,1,0,1 for 4 cycles each; tx=1 from edge 38. busy falls at edge 42. count 1→0 at edge 2.
- Fill/overflow (CLK_DIV=4, depth 4): writes 0x01..0x06 on consecutive cycles.
  - 0x01 popped immediately; 0x02–0x05 queued, giving full=1, count=4.
  - 0x06 dropped, overflow=1.
  - Decoded tx stream is exactly 01 02 03 04 05.
- Back-to-back spacing: two queued bytes 0x00, 0xFF (CLK_DIV=4) → second start bit begins exactly 41 cycles after the first. Exactly one high idle cycle between frames.
- CLK_DIV=1: byte 0x3C → tx sequence 0,0,0,1,1,1,1,0,0,1, one cycle per bit.
- Reset mid-frame: RESET=0 during DATA bit 3 → tx=1 with no clock edge, count=0, overflow=0. After release, no residual bits until the next write.
- UART_TX_PARITY_EN defined: bytes 0x07 and 0x03 → parity bit 1 and 0 respectively, each held CLK_DIV cycles before the stop bit.
